// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit integer divider (DIV / DIVU) for the execute stage.
//
// One restoring radix-2 step per clock. A non-zero-divisor operation starts in
// IDLE, runs 32 steps in BUSY and presents its result during FINISH, where
// done pulses for one cycle. A zero divisor, or (optionally) a dividend smaller
// in magnitude than the divisor, skips BUSY and finishes on the start edge.
//
// Optional feature macro:
//   DIV_EARLY_OUT_EN  when defined, |opa| < |opb| finishes immediately
//                     with quotient 0 and remainder opa.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   start       request a divide (sampled only in IDLE)
//   signed_div  1 = signed DIV, 0 = unsigned DIVU (sampled with start)
//   opa, opb    dividend, divisor (sampled with start)
//   cancel      flush of the issuing instruction; aborts to IDLE
//   busy        combinational stall request to the execute stage
//   done        one-cycle pulse, results valid this cycle
//   result_hi   remainder (HI)
//   result_lo   quotient (LO)

module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} stateT;

  stateT       state;
  logic [31:0] divisorMag;
  logic [31:0] quotAcc;     // dividend bits shift out the top, quotient bits shift in
  logic [31:0] remAcc;
  logic [5:0]  counter;
  logic        negQuot;
  logic        negRem;

  // Operand magnitudes; 0x80000000 maps to itself, which is the correct
  // unsigned magnitude 2^31.
  logic [31:0] magA;
  logic [31:0] magB;
  logic        earlyOut;

  assign magA = (signed_div && opa[31]) ? (~opa + 32'd1) : opa;
  assign magB = (signed_div && opb[31]) ? (~opb + 32'd1) : opb;

`ifdef DIV_EARLY_OUT_EN
  assign earlyOut = (magA < magB);
`else
  assign earlyOut = 1'b0;
`endif

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in 33 bits and a negative trial shows up in bit 32.
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] nextRem;
  logic [31:0] nextQuot;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted  = {remAcc, quotAcc[31]};
    trial    = shifted - {1'b0, divisorMag};
    nextRem  = shifted[31:0];
    nextQuot = {quotAcc[30:0], 1'b0};
    if (!trial[32]) begin
      nextRem  = trial[31:0];
      nextQuot = {quotAcc[30:0], 1'b1};
    end
  end

  // Reset is gated in so busy drops the instant rst goes low, even with start high.
  assign busy = rst && ((state == BUSY) || (state == IDLE && start && !cancel));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the default done <= 0 is overridden later in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      divisorMag <= '0;
      quotAcc    <= '0;
      remAcc     <= '0;
      counter    <= '0;
      negQuot    <= 1'b0;
      negRem     <= 1'b0;
      done       <= 1'b0;
      result_hi  <= '0;
      result_lo  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (opb == 32'd0) begin
              result_hi <= opa;
              result_lo <= 32'hFFFF_FFFF;
              done      <= 1'b1;
              state     <= FINISH;
            end else if (earlyOut) begin
              result_hi <= opa;
              result_lo <= 32'd0;
              done      <= 1'b1;
              state     <= FINISH;
            end else begin
              divisorMag <= magB;
              quotAcc    <= magA;
              remAcc     <= 32'd0;
              negQuot    <= signed_div && (opa[31] ^ opb[31]);
              negRem     <= signed_div && opa[31];
              counter    <= 6'd0;
              state      <= BUSY;
            end
          end
        end

        BUSY: begin
          if (cancel) begin
            counter <= 6'd0;
            state   <= IDLE;
          end else begin
            remAcc  <= nextRem;
            quotAcc <= nextQuot;
            counter <= counter + 6'd1;
            if (counter == 6'd31) begin
              result_lo <= negQuot ? (~nextQuot + 32'd1) : nextQuot;
              result_hi <= negRem  ? (~nextRem  + 32'd1) : nextRem;
              done      <= 1'b1;
              state     <= FINISH;
            end
          end
        end

        FINISH: begin
          counter <= 6'd0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- scoreboard bench for div_unit.
// Stimulus pushes the expected {hi, lo, done cycle} computed with plain
// 64-bit arithmetic; a monitor pops and compares whenever done is seen.

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .result_hi  (result_hi),
    .result_lo  (result_lo)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned doneCyc;
  } expT;

  expT         sbq[$];
  expT         monExp;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: quotient/remainder from 64-bit arithmetic; done cycle offset
  // returned in doneCyc (1 for immediate finishes, 33 for the full run).
  function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    expT    e;
    longint sa, sb, q, r, absA, absB;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    absA = (sa < 0) ? -sa : sa;
    absB = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.doneCyc = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
      e.doneCyc = 33;
`ifdef DIV_EARLY_OUT_EN
      if (absA < absB) e.doneCyc = 1;
`endif
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        monExp = sbq.pop_front();
        check("result_hi", result_hi, monExp.hi);
        check("result_lo", result_lo, monExp.lo);
        check("done_cycle", cyc, monExp.doneCyc);
      end
    end
  end

  // Presents start for exactly one cycle (cycle k); returns #1 after edge k.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn, input bit expect_done);
    expT e;
    @(posedge clk);
    #1;
    opa = a;
    opb = b;
    signed_div = sgn;
    start = 1'b1;
    if (expect_done) begin
      e = model(a, b, sgn);
      e.doneCyc = e.doneCyc + cyc;
      sbq.push_back(e);
      lastHi = e.hi;
      lastLo = e.lo;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    issue(a, b, sgn, 1'b1);
    waitDrain();
  endtask

  initial begin
    int          badBusy;
    logic [31:0] a, b;
    logic        sgn;

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", result_hi, 32'd0);
    check("reset_lo", result_lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // DIVU 100/7 with the busy window checked over cycles k..k+32
    @(posedge clk);
    #1;
    opa = 32'd100;
    opb = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    sbq.push_back('{hi: 32'd2, lo: 32'd14, doneCyc: cyc + 33});
    lastHi = 32'd2;
    lastLo = 32'd14;
    badBusy = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (!busy) badBusy++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("busy_window_low_cycles", badBusy, 32'd0);
    check("busy_in_finish", {31'd0, busy}, 32'd0);
    waitDrain();

    // Signed corner cases and divide by zero
    doOp(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    check("div_neg7_by_2_lo", lastLo, 32'hFFFF_FFFD);
    doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("div_overflow_lo", lastLo, 32'h8000_0000);
    doOp(32'd5, 32'd0, 1'b0);
    doOp(32'd3, 32'd10, 1'b0);
    doOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

    // Cancel at BUSY counter 10: no done, results keep prior values
    issue(32'd12345, 32'd17, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy_after", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    check("cancel_hi_kept", result_hi, lastHi);
    check("cancel_lo_kept", result_lo, lastLo);

    // start with cancel in the same cycle: no busy, no operation
    @(posedge clk);
    #1;
    opa = 32'd77;
    opb = 32'd5;
    start = 1'b1;
    cancel = 1'b1;
    #1;
    check("start_cancel_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    cancel = 1'b0;
    repeat (40) @(posedge clk);
    check("start_cancel_hi_kept", result_hi, lastHi);

    // start pulsed during BUSY must not re-sample operands
    issue(32'd1000, 32'd10, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    opa = 32'd9;
    opb = 32'd2;
    signed_div = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain();

    // Reset at BUSY counter 20, with start held high during reset
    issue(32'hDEAD_BEEF, 32'h0000_0123, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    start = 1'b1;
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", result_hi, 32'd0);
    check("midrst_lo", result_lo, 32'd0);
    start = 1'b0;
    lastHi = '0;
    lastLo = '0;
    @(negedge clk);
    rst = 1'b1;
    doOp(32'd9, 32'd3, 1'b0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = $urandom_range(0, 255); b = $urandom_range(1, 31); end
        2: begin a = $urandom_range(0, 100); b = $urandom; end
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        4: begin a = $urandom; b = $urandom_range(1, 9); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      doOp(a, b, sgn);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
